// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destination registers past D and derives the
// stall and forwarding selects, and tracks occupancy of the multiply/divide unit.
module hazard_scoreboard #(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [2:0] d_rs_tuse,
  input  logic [2:0] d_rt_tuse,
  input  logic [4:0] d_wa,
  input  logic [2:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  input  logic       flush,
  output logic       stall,
  output logic [2:0] fwd_rs_sel,
  output logic [2:0] fwd_rt_sel,
  output logic       md_busy
);

  localparam logic [2:0] TuseNone = 3'b111;

  // Index k holds slot k+1 (E, M, W, ...).
  logic [DEPTH-1:0][4:0] r_wa;
  logic [DEPTH-1:0][2:0] r_tnew;
  logic [DEPTH-1:0]      r_valid;
  logic [3:0]            r_md_cnt;

  logic       w_rs_hit, w_rt_hit;
  logic [2:0] w_rs_idx, w_rt_idx;
  logic [2:0] w_rs_tnew, w_rt_tnew;
  logic       w_rs_stall, w_rt_stall, w_md_stall;

  function automatic logic [2:0] sat_dec(input logic [2:0] t);
    return (t == 3'd0) ? 3'd0 : t - 3'd1;
  endfunction

  // Scan from the oldest slot down so the youngest match overwrites.
  always_comb begin
    w_rs_hit  = 1'b0;
    w_rs_idx  = 3'd0;
    w_rs_tnew = 3'd0;
    w_rt_hit  = 1'b0;
    w_rt_idx  = 3'd0;
    w_rt_tnew = 3'd0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (r_valid[k] && (r_wa[k] != 5'd0) && (r_wa[k] == d_rs)) begin
        w_rs_hit  = 1'b1;
        w_rs_idx  = 3'(k + 1);
        w_rs_tnew = r_tnew[k];
      end
      if (r_valid[k] && (r_wa[k] != 5'd0) && (r_wa[k] == d_rt)) begin
        w_rt_hit  = 1'b1;
        w_rt_idx  = 3'(k + 1);
        w_rt_tnew = r_tnew[k];
      end
    end
  end

  always_comb begin
    w_rs_stall = (d_rs_tuse != TuseNone) && w_rs_hit && (w_rs_tnew > d_rs_tuse);
    w_rt_stall = (d_rt_tuse != TuseNone) && w_rt_hit && (w_rt_tnew > d_rt_tuse);
    w_md_stall = d_md_use && md_busy;
    stall      = !flush && (w_rs_stall || w_rt_stall || w_md_stall);
    fwd_rs_sel = (w_rs_hit && (w_rs_tnew == 3'd0)) ? w_rs_idx : 3'd0;
    fwd_rt_sel = (w_rt_hit && (w_rt_tnew == 3'd0)) ? w_rt_idx : 3'd0;
  end

  assign md_busy = (r_md_cnt != 4'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wa    <= '0;
      r_tnew  <= '0;
      r_valid <= '0;
    end else if (flush) begin
      r_wa    <= '0;
      r_tnew  <= '0;
      r_valid <= '0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        r_wa[k]    <= r_wa[k-1];
        r_tnew[k]  <= sat_dec(r_tnew[k-1]);
        r_valid[k] <= r_valid[k-1];
      end
      if (stall) begin
        r_wa[0]    <= 5'd0;
        r_tnew[0]  <= 3'd0;
        r_valid[0] <= 1'b0;
      end else begin
        r_wa[0]    <= d_wa;
        r_tnew[0]  <= sat_dec(d_tnew);
        r_valid[0] <= 1'b1;
      end
    end
  end

  // The counter ignores flush so an already issued multiply/divide runs to completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_md_cnt <= 4'd0;
    end else if (d_md_start && !stall && !flush) begin
      r_md_cnt <= d_md_div ? 4'(DIV_LAT) : 4'(MULT_LAT);
    end else if (r_md_cnt != 4'd0) begin
      r_md_cnt <= r_md_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters (DEPTH=3, MULT_LAT=5,
// DIV_LAT=10); inputs change 1 time unit after a rising edge, outputs are sampled 2 units later.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [2:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       d_md_start, d_md_div, d_md_use, flush;
  logic       stall, md_busy;
  logic [2:0] fwd_rs_sel, fwd_rt_sel;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_rs_tuse (d_rs_tuse),
    .d_rt_tuse (d_rt_tuse),
    .d_wa      (d_wa),
    .d_tnew    (d_tnew),
    .d_md_start(d_md_start),
    .d_md_div  (d_md_div),
    .d_md_use  (d_md_use),
    .flush     (flush),
    .stall     (stall),
    .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel),
    .md_busy   (md_busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_d();
    d_rs = 5'd0; d_rt = 5'd0; d_rs_tuse = 3'b111; d_rt_tuse = 3'b111;
    d_wa = 5'd0; d_tnew = 3'd0;
    d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0; flush = 1'b0;
  endtask

  initial begin
    idle_d();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_stall", 8'(stall), 8'd0);
    chk("rst_rs", 8'(fwd_rs_sel), 8'd0);
    chk("rst_rt", 8'(fwd_rt_sel), 8'd0);
    chk("rst_busy", 8'(md_busy), 8'd0);
    d_rs = 5'd5; d_rs_tuse = 3'd0;
    #1;
    chk("rst_stall_rd", 8'(stall), 8'd0);

    // Load-use: lw $8 then addu reading $8 in E.
    idle_d(); d_wa = 5'd8; d_tnew = 3'd3;
    #1 chk("lw_nostall", 8'(stall), 8'd0);
    tick();
    idle_d(); d_rs = 5'd8; d_rs_tuse = 3'd1; d_wa = 5'd10; d_tnew = 3'd2;
    #1 chk("lu_stall", 8'(stall), 8'd1);
    chk("lu_rs0", 8'(fwd_rs_sel), 8'd0);
    tick();
    #1 chk("lu_release", 8'(stall), 8'd0);
    // lw sits in M with its data still one cycle away, so nothing is forwardable yet.
    chk("lu_rs_m", 8'(fwd_rs_sel), 8'd0);
    tick();
    idle_d(); d_rs = 5'd8; d_rs_tuse = 3'd1;
    #1 chk("lu_rs_w", 8'(fwd_rs_sel), 8'd3);
    chk("lu_w_stall", 8'(stall), 8'd0);
    idle_d();
    repeat (3) tick();

    // Branch on ALU result, rs and rt both read the same register.
    d_wa = 5'd9; d_tnew = 3'd2;
    tick();
    idle_d(); d_rs = 5'd9; d_rt = 5'd9; d_rs_tuse = 3'd0; d_rt_tuse = 3'd0;
    #1 chk("br_stall", 8'(stall), 8'd1);
    tick();
    #1 chk("br_release", 8'(stall), 8'd0);
    chk("br_rs", 8'(fwd_rs_sel), 8'd2);
    chk("br_rt", 8'(fwd_rt_sel), 8'd2);
    idle_d();
    repeat (3) tick();

    // Register zero never matches.
    d_wa = 5'd0; d_tnew = 3'd2;
    tick();
    idle_d(); d_rs_tuse = 3'd0; d_rt_tuse = 3'd0;
    #1 chk("r0_stall", 8'(stall), 8'd0);
    chk("r0_rs", 8'(fwd_rs_sel), 8'd0);
    idle_d();
    repeat (3) tick();

    // Youngest match wins; Tuse=7 never stalls; tnew equal to Tuse does not stall.
    d_wa = 5'd4; d_tnew = 3'd1;
    tick();
    d_rs = 5'd4;
    #1 chk("pri_rs1", 8'(fwd_rs_sel), 8'd1);
    tick();
    d_wa = 5'd5; d_tnew = 3'd3;
    #1 chk("pri_both", 8'(fwd_rs_sel), 8'd1);
    tick();
    idle_d(); d_rs = 5'd5; d_rt = 5'd5; d_rt_tuse = 3'd2;
    #1 chk("tuse_eq", 8'(stall), 8'd0);
    chk("tuse_rs0", 8'(fwd_rs_sel), 8'd0);
    d_rt_tuse = 3'd1;
    #1 chk("tuse_gt", 8'(stall), 8'd1);
    idle_d();
    repeat (3) tick();

    // Divide followed by mflo: 10 stall cycles.
    d_md_start = 1'b1; d_md_div = 1'b1; d_md_use = 1'b1;
    #1 chk("div_issue", 8'(stall), 8'd0);
    tick();
    idle_d(); d_md_use = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 chk("div_stall", 8'(stall), 8'd1);
      chk("div_busy", 8'(md_busy), 8'd1);
      tick();
    end
    #1 chk("div_done", 8'(stall), 8'd0);
    chk("div_idle", 8'(md_busy), 8'd0);
    idle_d();
    repeat (3) tick();

    // Flush mid-hazard with a multiply in flight.
    d_md_start = 1'b1; d_md_use = 1'b1;
    tick();
    idle_d(); d_wa = 5'd8; d_tnew = 3'd3;
    tick();
    idle_d(); d_rs = 5'd8; d_rs_tuse = 3'd1;
    #1 chk("fl_pre", 8'(stall), 8'd1);
    flush = 1'b1;
    #1 chk("fl_win", 8'(stall), 8'd0);
    tick();
    flush = 1'b0; d_rt = 5'd8; d_rt_tuse = 3'd0;
    #1 chk("fl_clear", 8'(stall), 8'd0);
    chk("fl_rs", 8'(fwd_rs_sel), 8'd0);
    chk("fl_busy3", 8'(md_busy), 8'd1);
    tick();
    tick();
    #1 chk("fl_busy1", 8'(md_busy), 8'd1);
    tick();
    #1 chk("fl_busy0", 8'(md_busy), 8'd0);
    idle_d();
    repeat (3) tick();

    // Reset mid-divide, coinciding with flush.
    d_md_start = 1'b1; d_md_div = 1'b1;
    tick();
    idle_d();
    repeat (3) tick();
    d_wa = 5'd8; d_tnew = 3'd1;
    tick();
    idle_d(); d_md_use = 1'b1; d_rs = 5'd8;
    #1 chk("rd_busy", 8'(md_busy), 8'd1);
    chk("rd_stall", 8'(stall), 8'd1);
    chk("rd_rs", 8'(fwd_rs_sel), 8'd1);
    reset = 1'b0; flush = 1'b1;
    tick();
    reset = 1'b1; flush = 1'b0;
    #1 chk("rd_busy0", 8'(md_busy), 8'd0);
    chk("rd_stall0", 8'(stall), 8'd0);
    chk("rd_rs0", 8'(fwd_rs_sel), 8'd0);
    chk("rd_rt0", 8'(fwd_rt_sel), 8'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
